xadc_sample_loader: RTL and testbench
=====================================

Name: xadc_sample_loader

Overview:
Upstream feeder for the DFR input memory. On a start pulse it samples the XADC over the DRP port at a programmable period and writes num_samples conversion codes into consecutive input-memory addresses starting at 0. Its memory-side outputs drive the input_mem write port while the core is idle, so the reservoir then consumes real analog data.

Parameters:
ADDR_WIDTH, 16, input-memory address width
DATA_WIDTH, 32, input-memory word width
DRP_CHANNEL_ADDR, 7'h03, DRP status register read each sample (VP/VN result)
DRDY_TIMEOUT, 64, cycles to wait for drp_drdy before abandoning a read

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a capture run when idle
num_samples  in  ADDR_WIDTH  samples to capture; latched at start
sample_period  in  32  clk cycles between sample ticks; latched at start; 0 treated as 1
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at end of run
overrun  out  1  sticky: a tick arrived while a read was in progress
timeout  out  1  sticky: a DRP read hit DRDY_TIMEOUT
drp_den  out  1  DRP enable strobe
drp_dwe  out  1  DRP write enable; tied 0
drp_daddr  out  7  DRP address
drp_di  out  16  DRP write data; tied 0
drp_do  in  16  DRP read data
drp_drdy  in  1  DRP read data valid
mem_addr  out  ADDR_WIDTH  input-memory write address
mem_din  out  DATA_WIDTH  input-memory write data
mem_wen  out  1  input-memory write enable

Behaviour:
- Reset: all outputs 0. FSM enters IDLE. Counters and sticky flags clear. Reset mid-run aborts immediately with no further writes.
- FSM states: IDLE, WAIT_TICK, DRP_REQ, DRP_WAIT, WRITE, FINISH.
- IDLE:
  - On start, latch num_samples and max(sample_period,1).
  - Clear index, overrun and timeout.
  - Load the period counter with 0 so the first tick occurs at once.
  - If num_samples==0, go to FINISH; otherwise go to WAIT_TICK.
  - start while not IDLE is ignored.
- Period counter:
  - Free-runs during the run and reloads period-1 on reaching 0; a tick is asserted when it is 0.
  - Spacing is exact when period >= capture latency (DRP latency + 3).
- WAIT_TICK: on tick, go to DRP_REQ.
- Overrun: a tick seen in DRP_REQ, DRP_WAIT or WRITE is dropped and sets overrun. The next sample waits for the following tick.
- DRP_REQ: drp_den=1 and drp_daddr=DRP_CHANNEL_ADDR for exactly one cycle, then go to DRP_WAIT. drp_daddr holds its value otherwise.
- DRP_WAIT:
  - On drp_drdy, capture mem_din = zero-extended drp_do[15:4] (12-bit code in bits [11:0], upper bits 0), then go to WRITE.
  - If DRDY_TIMEOUT cycles pass without drp_drdy, capture mem_din=0, set timeout, and go to WRITE.
  - drp_drdy outside DRP_WAIT is ignored.
- WRITE:
  - mem_wen=1 for one cycle with mem_addr=index; then index increments.
  - If index+1==num_samples, go to FINISH; otherwise go to WAIT_TICK.
- FINISH: done=1 and busy=0 for one cycle, then go to IDLE.
  - mem_addr and mem_din retain their last values.
  - overrun and timeout remain until the next accepted start or reset.
- busy: 1 in every state except IDLE and FINISH.
- index width: ADDR_WIDTH. num_samples=2^ADDR_WIDTH-1 is the maximum; there is no wrap.
- Latency: start to first drp_den is 2 cycles (IDLE to WAIT_TICK with tick, then DRP_REQ). drp_drdy to mem_wen is 1 cycle.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0; no drp_den; no mem_wen.
- num_samples=4, sample_period=20, DRP model returns drdy 3 cycles after den with do=16'hABC0,16'h1230,16'hFFF0,16'h0010 -> writes at addr 0..3 of 32'hABC,32'h123,32'hFFF,32'h001. drp_den pulses are 20 cycles apart. done pulses once; overrun=0.
- num_samples=0 with start -> no drp_den; done pulse 1 cycle after start; busy never high.
- sample_period=2, DRP latency 3, num_samples=3 -> overrun=1; exactly 3 writes at addr 0..2; done asserted.
- DRP model never asserts drdy, num_samples=2 -> each read abandons after 64 cycles; addr 0,1 written with 0; timeout=1; done asserted.
- Assert rst in DRP_WAIT of sample 2 of 5 -> outputs 0 next cycle; no further mem_wen; a new start restarts from addr 0 with the flags cleared.

Source files
------------

// File: rtl/xadc_sample_loader.sv
// Captures num_samples XADC conversions over DRP at a programmable period and
// writes the 12-bit codes to consecutive input-memory addresses from 0.
module xadc_sample_loader #(
  parameter int              ADDR_WIDTH       = 16,
  parameter int              DATA_WIDTH       = 32,
  parameter logic [6:0]      DRP_CHANNEL_ADDR = 7'h03,
  parameter int              DRDY_TIMEOUT     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] num_samples,
  input  logic [31:0]           sample_period,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic                  timeout,
  output logic                  drp_den,
  output logic                  drp_dwe,
  output logic [6:0]            drp_daddr,
  output logic [15:0]           drp_di,
  input  logic [15:0]           drp_do,
  input  logic                  drp_drdy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_wen
);

  localparam int WAIT_W = $clog2(DRDY_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_TICK = 3'd1;
  localparam logic [2:0] S_DRP_REQ   = 3'd2;
  localparam logic [2:0] S_DRP_WAIT  = 3'd3;
  localparam logic [2:0] S_WRITE     = 3'd4;
  localparam logic [2:0] S_FINISH    = 3'd5;

  logic [2:0]            state_q,   state_d;
  logic [ADDR_WIDTH-1:0] num_q,     num_d;
  logic [ADDR_WIDTH-1:0] index_q,   index_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [DATA_WIDTH-1:0] din_q,     din_d;
  logic [31:0]           period_q,  period_d;
  logic [31:0]           per_cnt_q, per_cnt_d;
  logic [WAIT_W-1:0]     wait_q,    wait_d;
  logic [6:0]            daddr_q,   daddr_d;
  logic                  overrun_q, overrun_d;
  logic                  timeout_q, timeout_d;

  logic                  in_run;
  logic                  tick;
  logic [ADDR_WIDTH-1:0] index_inc;
  logic                  unused_lsbs;

  assign in_run      = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign tick        = in_run && (per_cnt_q == 32'd0);
  assign index_inc   = index_q + 1'b1;
  assign unused_lsbs = ^drp_do[3:0];

  always_comb begin
    // NOTE: every next-state signal gets a default here so no path can infer a latch.
    state_d   = state_q;
    num_d     = num_q;
    index_d   = index_q;
    addr_d    = addr_q;
    din_d     = din_q;
    period_d  = period_q;
    per_cnt_d = per_cnt_q;
    wait_d    = wait_q;
    daddr_d   = daddr_q;
    overrun_d = overrun_q;
    timeout_d = timeout_q;

    if (in_run) begin
      per_cnt_d = (per_cnt_q == 32'd0) ? period_q - 32'd1 : per_cnt_q - 32'd1;
    end

    // Ticks landing while a capture is in flight are dropped and flagged.
    if (tick && (state_q == S_DRP_REQ || state_q == S_DRP_WAIT || state_q == S_WRITE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d     = num_samples;
          period_d  = (sample_period == 32'd0) ? 32'd1 : sample_period;
          index_d   = '0;
          overrun_d = 1'b0;
          timeout_d = 1'b0;
          per_cnt_d = 32'd0;
          state_d   = (num_samples == '0) ? S_FINISH : S_WAIT_TICK;
        end
      end
      S_WAIT_TICK: begin
        if (tick) begin
          daddr_d = DRP_CHANNEL_ADDR;
          state_d = S_DRP_REQ;
        end
      end
      S_DRP_REQ: begin
        wait_d  = '0;
        state_d = S_DRP_WAIT;
      end
      S_DRP_WAIT: begin
        if (drp_drdy) begin
          din_d   = DATA_WIDTH'(drp_do[15:4]);
          addr_d  = index_q;
          state_d = S_WRITE;
        end else if (wait_q == WAIT_W'(DRDY_TIMEOUT - 1)) begin
          din_d     = '0;
          addr_d    = index_q;
          timeout_d = 1'b1;
          state_d   = S_WRITE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WRITE: begin
        index_d = index_inc;
        state_d = (index_inc == num_q) ? S_FINISH : S_WAIT_TICK;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      num_q     <= '0;
      index_q   <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      period_q  <= 32'd1;
      per_cnt_q <= 32'd0;
      wait_q    <= '0;
      daddr_q   <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      index_q   <= index_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      period_q  <= period_d;
      per_cnt_q <= per_cnt_d;
      wait_q    <= wait_d;
      daddr_q   <= daddr_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy      = in_run;
  assign done      = (state_q == S_FINISH);
  assign drp_den   = (state_q == S_DRP_REQ);
  assign mem_wen   = (state_q == S_WRITE);
  assign drp_dwe   = 1'b0;
  assign drp_di    = 16'h0000;
  assign drp_daddr = daddr_q;
  assign mem_addr  = addr_q;
  assign mem_din   = din_q;
  assign overrun   = overrun_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_xadc_sample_loader.sv
// Bench for xadc_sample_loader: a DRP responder with configurable latency and a
// reference derived from the capture rules (code = do[15:4], tick spacing math).
module tb_xadc_sample_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_samples;
  logic [31:0] sample_period;
  logic        busy, done, overrun, timeout;
  logic        drp_den, drp_dwe, drp_drdy;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di, drp_do;
  logic [15:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_wen;

  xadc_sample_loader dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .sample_period(sample_period), .busy(busy), .done(done), .overrun(overrun),
    .timeout(timeout), .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr),
    .drp_di(drp_di), .drp_do(drp_do), .drp_drdy(drp_drdy), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_wen(mem_wen)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Stimulus controls (written by the initial block, read by the responder).
  int          drp_latency = 3;
  bit          drdy_en = 1'b1;
  int          den_base = 0;
  logic [15:0] drp_data [16];

  // Observations (written only by the negedge monitor).
  int          cyc = 0;
  int          den_times[$];
  logic [15:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          done_times[$];
  int          busy_cycles = 0;
  int          pend = 0;
  logic [15:0] pend_data = 16'h0;

  initial begin
    drp_drdy = 1'b0;
    drp_do   = 16'h0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    drp_drdy = 1'b0;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        drp_drdy = 1'b1;
        drp_do   = pend_data;
      end
    end
    if (drp_den) begin
      den_times.push_back(cyc);
      if (drdy_en) begin
        pend      = drp_latency;
        pend_data = drp_data[(den_times.size() - 1 - den_base) & 15];
      end
    end
    if (mem_wen) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_din);
    end
    if (done) done_times.push_back(cyc);
    if (busy) busy_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".busy"},    32'(busy), 0);
    check({tag, ".done"},    32'(done), 0);
    check({tag, ".overrun"}, 32'(overrun), 0);
    check({tag, ".timeout"}, 32'(timeout), 0);
    check({tag, ".den"},     32'(drp_den), 0);
    check({tag, ".dwe"},     32'(drp_dwe), 0);
    check({tag, ".daddr"},   32'(drp_daddr), 0);
    check({tag, ".di"},      32'(drp_di), 0);
    check({tag, ".addr"},    32'(mem_addr), 0);
    check({tag, ".din"},     mem_din, 0);
    check({tag, ".wen"},     32'(mem_wen), 0);
  endtask

  task automatic pulse_start(input int n, input int p, output int start_cyc);
    num_samples   = 16'(n);
    sample_period = 32'(p);
    @(negedge clk);
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One complete capture run compared against the rule-level expectation.
  task automatic run(input string tag, input int n, input int p, input int lat, input bit resp);
    int wb, db, dnb, bb, sc, guard, peff, spacing, t_done;
    bit exp_ovr;
    wb = wr_addr.size(); db = den_times.size(); dnb = done_times.size(); bb = busy_cycles;
    drp_latency = lat; drdy_en = resp; den_base = db;
    pulse_start(n, p, sc);
    guard = 0;
    while (done_times.size() == dnb && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check({tag, ".done_seen"}, 32'(guard < 5000), 1);
    repeat (3) @(negedge clk);
    check({tag, ".done_count"}, done_times.size() - dnb, 1);
    check({tag, ".writes"}, wr_addr.size() - wb, n);
    for (int i = 0; i < n && wb + i < wr_addr.size(); i++) begin
      check($sformatf("%s.addr%0d", tag, i), 32'(wr_addr[wb + i]), i);
      check($sformatf("%s.data%0d", tag, i), wr_data[wb + i],
            resp ? {20'h0, drp_data[i][15:4]} : 32'h0);
    end
    t_done = (done_times.size() > dnb) ? done_times[dnb] : -1;
    check({tag, ".busy_cycles"}, busy_cycles - bb, (t_done < 0) ? -1 : t_done - sc - 1);
    check({tag, ".timeout"}, 32'(timeout), 32'(!resp && n > 0));
    if (n == 0) begin
      check({tag, ".done_lat"}, t_done - sc, 1);
      check({tag, ".no_den"}, den_times.size() - db, 0);
    end else begin
      check({tag, ".first_den"}, den_times[db] - sc, 2);
      check({tag, ".last_addr"}, 32'(mem_addr), n - 1);
      check({tag, ".last_din"}, mem_din, resp ? {20'h0, drp_data[n-1][15:4]} : 32'h0);
      check({tag, ".daddr"}, 32'(drp_daddr), 32'h03);
      if (resp) begin
        peff    = (p == 0) ? 1 : p;
        exp_ovr = (peff < lat + 3);
        spacing = ((lat + 3 + peff - 1) / peff) * peff;
        check({tag, ".overrun"}, 32'(overrun), 32'(exp_ovr));
        for (int k = 1; k < n && db + k < den_times.size(); k++)
          check($sformatf("%s.gap%0d", tag, k), den_times[db + k] - den_times[db + k - 1], spacing);
      end
    end
  endtask

  initial begin
    int sc, wb, dnb, guard, n, p, lat;
    rst = 1'b1; start = 1'b0; num_samples = '0; sample_period = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_quiet("idle");
    check("idle.den_count", den_times.size(), 0);
    check("idle.wen_count", wr_addr.size(), 0);

    drp_data[0] = 16'hABC0; drp_data[1] = 16'h1230;
    drp_data[2] = 16'hFFF0; drp_data[3] = 16'h0010;
    run("basic", 4, 20, 3, 1'b1);
    run("zero", 0, 20, 3, 1'b1);
    for (int i = 0; i < 16; i++) drp_data[i] = 16'($urandom);
    run("ovr", 3, 2, 3, 1'b1);
    run("tmo", 2, 10, 3, 1'b0);

    // Abort in DRP_WAIT of the second sample; flags from the prior run must clear too.
    drp_latency = 3; drdy_en = 1'b1; den_base = den_times.size();
    wb = wr_addr.size(); dnb = done_times.size();
    pulse_start(5, 20, sc);
    guard = 0;
    while (den_times.size() < den_base + 2 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("rst.den2_seen", 32'(guard < 500), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("rst");
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("rst.writes", wr_addr.size() - wb, 1);
    check("rst.no_done", done_times.size() - dnb, 0);
    check("rst.busy", 32'(busy), 0);
    run("restart", 3, 12, 4, 1'b1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) drp_data[i] = 16'($urandom);
      n   = $urandom_range(1, 6);
      p   = $urandom_range(0, 12);
      lat = $urandom_range(1, 5);
      run($sformatf("rnd%0d", r), n, p, lat, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
